// File: rtl/pipeline_controller_pkg.sv
// Shared types for the pipeline controller: per-stage control pair, FSM states
// and the operand bypass source encoding.
package pipeline_controller_pkg;

    typedef struct packed {
        logic stall;
        logic flush;
    } StageCtrl;

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        MULDIV_BUSY = 2'd1,
        MEM_WAIT    = 2'd2
    } CtrlState;

    typedef enum logic [1:0] {
        BYPASS_MA = 2'd0,
        BYPASS_WB = 2'd1,
        BYPASS_RF = 2'd2
    } BypassSrc;

endpackage

// File: rtl/pipeline_controller_bypass_selector.sv
// Per-operand forwarding mux: memory-access result beats writeback result,
// which beats the register-file value. Register x0 is never forwarded.
module bypass_selector
    import pipeline_controller_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs_addr_i,
    input  logic [XLEN-1:0]       rf_data_i,
    input  logic [REG_ADDR_W-1:0] ma_rd_addr_i,
    input  logic                  ma_reg_write_i,
    input  logic [XLEN-1:0]       ma_result_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr_i,
    input  logic                  wb_reg_write_i,
    input  logic [XLEN-1:0]       wb_result_i,
    output logic [XLEN-1:0]       data_o
);

    BypassSrc src;
    logic     rs_nonzero;

    assign rs_nonzero = (rs_addr_i != '0);

    always_comb begin
        src = BYPASS_RF;
        if (ma_reg_write_i && (ma_rd_addr_i == rs_addr_i) && rs_nonzero) begin
            src = BYPASS_MA;
        end else if (wb_reg_write_i && (wb_rd_addr_i == rs_addr_i) && rs_nonzero) begin
            src = BYPASS_WB;
        end
    end

    always_comb begin
        data_o = rf_data_i;
        case (src)
            BYPASS_MA: data_o = ma_result_i;
            BYPASS_WB: data_o = wb_result_i;
            default:   data_o = rf_data_i;
        endcase
    end

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline hazard controller: load-use bubbles, branch redirects, mul/div
// occupancy, data-memory wait states, operand forwarding and perf counters.
module pipeline_controller
    import pipeline_controller_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] decRs1Addr,
    input  logic [REG_ADDR_W-1:0] decRs2Addr,
    input  logic [REG_ADDR_W-1:0] exRs1Addr,
    input  logic [REG_ADDR_W-1:0] exRs2Addr,
    input  logic [XLEN-1:0]       exRs1Data,
    input  logic [XLEN-1:0]       exRs2Data,
    input  logic [REG_ADDR_W-1:0] exRdAddr,
    input  logic                  exRegWrite,
    input  logic                  exIsLoad,
    input  logic [REG_ADDR_W-1:0] maRdAddr,
    input  logic                  maRegWrite,
    input  logic [XLEN-1:0]       maResult,
    input  logic [REG_ADDR_W-1:0] wbRdAddr,
    input  logic                  wbRegWrite,
    input  logic [XLEN-1:0]       wbResult,
    input  logic                  exRedirect,
    input  logic [XLEN-1:0]       exRedirectPc,
    input  logic                  exMulDivStart,
    input  logic                  mulDivDone,
    input  logic                  maMemBusy,
    output logic [XLEN-1:0]       irregPc,
    output StageCtrl              fetchStage,
    output StageCtrl              decodeStage,
    output StageCtrl              executeStage,
    output StageCtrl              memoryAccessStage,
    output logic                  mulDivClear,
    output logic [XLEN-1:0]       bypassedRs1,
    output logic [XLEN-1:0]       bypassedRs2,
    output logic [CNT_W-1:0]      stallCycles,
    output logic [CNT_W-1:0]      flushCount
);

    CtrlState         state_q, state_d;
    logic             pending_q, pending_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             redirect_taken;
    logic             load_use;
    logic             muldiv_active;

    assign load_use = exIsLoad && exRegWrite && (exRdAddr != '0) &&
                      ((exRdAddr == decRs1Addr) || (exRdAddr == decRs2Addr));

    // A mul/div is still occupying execute either in its own state or parked behind a memory wait.
    assign muldiv_active = (state_q == MULDIV_BUSY) || ((state_q == MEM_WAIT) && pending_q);

    always_comb begin
        state_d           = state_q;
        pending_d         = pending_q;
        fetchStage        = '0;
        decodeStage       = '0;
        executeStage      = '0;
        memoryAccessStage = '0;
        irregPc           = '0;
        mulDivClear       = 1'b0;
        redirect_taken    = 1'b0;

        if (maMemBusy) begin
            // Memory wait freezes everything, so a redirect or new mul/div start is held by execute.
            fetchStage.stall        = 1'b1;
            decodeStage.stall       = 1'b1;
            executeStage.stall      = 1'b1;
            memoryAccessStage.stall = 1'b1;
            state_d                 = MEM_WAIT;
            if (state_q == MULDIV_BUSY) begin
                pending_d = !mulDivDone;
            end else if ((state_q == MEM_WAIT) && mulDivDone) begin
                pending_d = 1'b0;
            end
        end else if (exRedirect) begin
            irregPc           = exRedirectPc;
            decodeStage.flush  = 1'b1;
            executeStage.flush = 1'b1;
            redirect_taken    = 1'b1;
            mulDivClear       = muldiv_active;
            pending_d         = 1'b0;
            state_d           = RUN;
        end else if (muldiv_active && !mulDivDone) begin
            fetchStage.stall        = 1'b1;
            decodeStage.stall       = 1'b1;
            executeStage.stall      = 1'b1;
            memoryAccessStage.flush = 1'b1;
            pending_d               = 1'b0;
            state_d                 = MULDIV_BUSY;
        end else begin
            pending_d = 1'b0;
            state_d   = RUN;
            if (load_use) begin
                fetchStage.stall   = 1'b1;
                decodeStage.stall  = 1'b1;
                executeStage.flush = 1'b1;
            end
            if ((state_q == RUN) && exMulDivStart) begin
                state_d = MULDIV_BUSY;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q + (fetchStage.stall ? CNT_W'(1) : CNT_W'(0));
        flush_cnt_d = flush_cnt_q + (redirect_taken ? CNT_W'(1) : CNT_W'(0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            pending_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stallCycles = stall_cnt_q;
    assign flushCount  = flush_cnt_q;

    bypass_selector #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_bypass_rs1 (
        .rs_addr_i      (exRs1Addr),
        .rf_data_i      (exRs1Data),
        .ma_rd_addr_i   (maRdAddr),
        .ma_reg_write_i (maRegWrite),
        .ma_result_i    (maResult),
        .wb_rd_addr_i   (wbRdAddr),
        .wb_reg_write_i (wbRegWrite),
        .wb_result_i    (wbResult),
        .data_o         (bypassedRs1)
    );

    bypass_selector #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_bypass_rs2 (
        .rs_addr_i      (exRs2Addr),
        .rf_data_i      (exRs2Data),
        .ma_rd_addr_i   (maRdAddr),
        .ma_reg_write_i (maRegWrite),
        .ma_result_i    (maResult),
        .wb_rd_addr_i   (wbRdAddr),
        .wb_reg_write_i (wbRegWrite),
        .wb_result_i    (wbResult),
        .data_o         (bypassedRs2)
    );

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed-vector bench: stimulus pushes expected outputs per cycle, a
// negedge monitor pops and compares them against the controller.
module tb_pipeline_controller;
    import pipeline_controller_pkg::*;

    localparam logic [31:0] D1 = 32'h1111_1111;
    localparam logic [31:0] D2 = 32'h2222_2222;
    // {f.stall,f.flush,d.stall,d.flush,e.stall,e.flush,m.stall,m.flush}
    localparam logic [7:0] C_NONE  = 8'b00_00_00_00;
    localparam logic [7:0] C_LDUSE = 8'b10_10_01_00;
    localparam logic [7:0] C_REDIR = 8'b00_01_01_00;
    localparam logic [7:0] C_MDIV  = 8'b10_10_10_01;
    localparam logic [7:0] C_MEM   = 8'b10_10_10_10;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  decRs1Addr, decRs2Addr, exRs1Addr, exRs2Addr, exRdAddr, maRdAddr, wbRdAddr;
    logic [31:0] exRs1Data, exRs2Data, maResult, wbResult, exRedirectPc;
    logic        exRegWrite, exIsLoad, maRegWrite, wbRegWrite, exRedirect;
    logic        exMulDivStart, mulDivDone, maMemBusy;
    logic [31:0] irregPc, bypassedRs1, bypassedRs2, stallCycles, flushCount;
    StageCtrl    fetchStage, decodeStage, executeStage, memoryAccessStage;
    logic        mulDivClear;

    typedef struct {
        string       name;
        logic [7:0]  ctrl;
        logic [31:0] pc;
        logic        clr;
        logic [31:0] b1;
        logic [31:0] b2;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_sc = 0;
    logic [31:0] exp_fc = 0;

    always #5 clk = ~clk;

    pipeline_controller dut (
        .clk(clk), .rst(rst),
        .decRs1Addr(decRs1Addr), .decRs2Addr(decRs2Addr),
        .exRs1Addr(exRs1Addr), .exRs2Addr(exRs2Addr),
        .exRs1Data(exRs1Data), .exRs2Data(exRs2Data),
        .exRdAddr(exRdAddr), .exRegWrite(exRegWrite), .exIsLoad(exIsLoad),
        .maRdAddr(maRdAddr), .maRegWrite(maRegWrite), .maResult(maResult),
        .wbRdAddr(wbRdAddr), .wbRegWrite(wbRegWrite), .wbResult(wbResult),
        .exRedirect(exRedirect), .exRedirectPc(exRedirectPc),
        .exMulDivStart(exMulDivStart), .mulDivDone(mulDivDone), .maMemBusy(maMemBusy),
        .irregPc(irregPc), .fetchStage(fetchStage), .decodeStage(decodeStage),
        .executeStage(executeStage), .memoryAccessStage(memoryAccessStage),
        .mulDivClear(mulDivClear), .bypassedRs1(bypassedRs1), .bypassedRs2(bypassedRs2),
        .stallCycles(stallCycles), .flushCount(flushCount)
    );

    task automatic cmp(input string nm, input string field, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s.%s got=%h want=%h", nm, field, act, expv);
        end
    endtask

    // Monitor: the controller presents a full set of outputs every cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            cmp(cur.name, "ctrl", {24'd0, fetchStage, decodeStage, executeStage, memoryAccessStage}, {24'd0, cur.ctrl});
            cmp(cur.name, "irregPc", irregPc, cur.pc);
            cmp(cur.name, "mulDivClear", {31'd0, mulDivClear}, {31'd0, cur.clr});
            cmp(cur.name, "rs1", bypassedRs1, cur.b1);
            cmp(cur.name, "rs2", bypassedRs2, cur.b2);
            cmp(cur.name, "stallCycles", stallCycles, cur.sc);
            cmp(cur.name, "flushCount", flushCount, cur.fc);
            $display("txn %-10s ctrl=%b pc=%h clr=%b rs1=%h rs2=%h sc=%0d fc=%0d",
                     cur.name, {fetchStage, decodeStage, executeStage, memoryAccessStage},
                     irregPc, mulDivClear, bypassedRs1, bypassedRs2, stallCycles, flushCount);
        end
    end

    // Inputs are already applied; queue this cycle's expectation and advance one clock.
    task automatic chk(input string nm, input logic [7:0] ctrl, input logic [31:0] pc,
                       input logic clr, input logic [31:0] b1, input logic [31:0] b2);
        exp_t e;
        e.name = nm; e.ctrl = ctrl; e.pc = pc; e.clr = clr;
        e.b1 = b1; e.b2 = b2; e.sc = exp_sc; e.fc = exp_fc;
        sb.push_back(e);
        if (rst) begin
            exp_sc = 0;
            exp_fc = 0;
        end else begin
            if (ctrl[7]) exp_sc = exp_sc + 1;
            if (ctrl[4]) exp_fc = exp_fc + 1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        {decRs1Addr, decRs2Addr, exRs1Addr, exRs2Addr, exRdAddr, maRdAddr, wbRdAddr} = '0;
        {exRs1Data, exRs2Data, maResult, wbResult, exRedirectPc} = '0;
        {exRegWrite, exIsLoad, maRegWrite, wbRegWrite, exRedirect} = '0;
        {exMulDivStart, mulDivDone, maMemBusy} = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset", C_NONE, 32'h0, 1'b0, 32'h0, 32'h0);

        // Forwarding priority
        exRs1Data = D1; exRs2Data = D2;
        maRdAddr = 5; maRegWrite = 1; maResult = 32'hAAAA_0000;
        wbRdAddr = 5; wbRegWrite = 1; wbResult = 32'h1234_5678;
        exRs1Addr = 5; exRs2Addr = 6;
        chk("fwd_ma", C_NONE, 32'h0, 1'b0, 32'hAAAA_0000, D2);
        maRegWrite = 0;
        chk("fwd_wb", C_NONE, 32'h0, 1'b0, 32'h1234_5678, D2);
        exRs1Addr = 0; maRdAddr = 0; maRegWrite = 1; exRs2Addr = 5;
        chk("fwd_x0", C_NONE, 32'h0, 1'b0, D1, 32'h1234_5678);
        maRegWrite = 0; wbRegWrite = 0; exRs2Addr = 0;

        // Load-use bubble, then redirect overriding load-use
        exIsLoad = 1; exRegWrite = 1; exRdAddr = 3; decRs2Addr = 3;
        chk("lduse", C_LDUSE, 32'h0, 1'b0, D1, D2);
        exIsLoad = 0;
        chk("lduse_end", C_NONE, 32'h0, 1'b0, D1, D2);
        exRedirect = 1; exRedirectPc = 32'h8000_1000;
        chk("redir", C_REDIR, 32'h8000_1000, 1'b0, D1, D2);
        exRedirect = 0;
        chk("redir_end", C_NONE, 32'h0, 1'b0, D1, D2);
        exIsLoad = 1; exRedirect = 1; exRedirectPc = 32'h0000_0040;
        chk("redir_lu", C_REDIR, 32'h0000_0040, 1'b0, D1, D2);
        exIsLoad = 0; exRegWrite = 0; exRedirect = 0; exRdAddr = 0; decRs2Addr = 0;

        // Mul/div: 33 stalled cycles, unstalled done cycle
        exMulDivStart = 1;
        chk("md_start", C_NONE, 32'h0, 1'b0, D1, D2);
        exMulDivStart = 0;
        for (int i = 0; i < 33; i++) chk("md_busy", C_MDIV, 32'h0, 1'b0, D1, D2);
        mulDivDone = 1;
        chk("md_done", C_NONE, 32'h0, 1'b0, D1, D2);
        mulDivDone = 0;
        chk("md_idle", C_NONE, 32'h0, 1'b0, D1, D2);

        // Mul/div cancelled by redirect
        exMulDivStart = 1;
        chk("mc_start", C_NONE, 32'h0, 1'b0, D1, D2);
        exMulDivStart = 0;
        for (int i = 0; i < 3; i++) chk("mc_busy", C_MDIV, 32'h0, 1'b0, D1, D2);
        exRedirect = 1; exRedirectPc = 32'h0000_0100;
        chk("mc_cancel", C_REDIR, 32'h0000_0100, 1'b1, D1, D2);
        exRedirect = 0;
        chk("mc_after", C_NONE, 32'h0, 1'b0, D1, D2);

        // Memory wait: 4 busy cycles
        maMemBusy = 1;
        for (int i = 0; i < 4; i++) chk("mem_wait", C_MEM, 32'h0, 1'b0, D1, D2);
        maMemBusy = 0;
        chk("mem_exit", C_NONE, 32'h0, 1'b0, D1, D2);

        // Memory wait during mul/div resumes the mul/div afterwards
        exMulDivStart = 1;
        chk("mp_start", C_NONE, 32'h0, 1'b0, D1, D2);
        exMulDivStart = 0;
        for (int i = 0; i < 2; i++) chk("mp_busy", C_MDIV, 32'h0, 1'b0, D1, D2);
        maMemBusy = 1;
        for (int i = 0; i < 2; i++) chk("mp_mem", C_MEM, 32'h0, 1'b0, D1, D2);
        maMemBusy = 0;
        chk("mp_resume", C_MDIV, 32'h0, 1'b0, D1, D2);
        mulDivDone = 1;
        chk("mp_done", C_NONE, 32'h0, 1'b0, D1, D2);
        mulDivDone = 0;
        chk("mp_idle", C_NONE, 32'h0, 1'b0, D1, D2);

        // Reset in the middle of a memory wait
        maMemBusy = 1;
        chk("rst_mem1", C_MEM, 32'h0, 1'b0, D1, D2);
        rst = 1;
        chk("rst_mem2", C_MEM, 32'h0, 1'b0, D1, D2);
        rst = 0; maMemBusy = 0;
        exRs1Data = 0; exRs2Data = 0;
        chk("rst_after", C_NONE, 32'h0, 1'b0, 32'h0, 32'h0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", sb.size());
        end
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
